// File: rtl/instruction_fetch_stage_pkg.sv
// Shared pipeline definitions: opcode constants, control-bit layout and fetch FSM states.
// Used by the fetch stage, its predecoder and anything that consumes if_control_signals.
package instruction_fetch_stage_pkg;

  localparam int CTRL_WIDTH_DEFAULT = 4;

  localparam int CTRL_VALID_BIT  = 0;
  localparam int CTRL_BRANCH_BIT = 1;
  localparam int CTRL_LOAD_BIT   = 2;
  localparam int CTRL_STORE_BIT  = 3;

  localparam logic [5:0] OPC_BRANCH = 6'b000100;
  localparam logic [5:0] OPC_LOAD   = 6'b100011;
  localparam logic [5:0] OPC_STORE  = 6'b101011;

  typedef enum logic [1:0] {
    ST_FETCH   = 2'd0,
    ST_WAIT    = 2'd1,
    ST_DELIVER = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/instruction_fetch_stage_predecode.sv
// Combinational predecode of the instruction opcode into IF/ID control bits; zero latency.
// No flow control of its own: it follows whatever the fetch stage presents.
module fetch_predecode
  import instruction_fetch_stage_pkg::*;
#(
  parameter int CTRL_WIDTH = CTRL_WIDTH_DEFAULT
) (
  input  logic                  i_valid,
  input  logic [5:0]            i_opcode,
  output logic [CTRL_WIDTH-1:0] o_ctrl
);

  always_comb begin
    o_ctrl                  = '0;
    o_ctrl[CTRL_VALID_BIT]  = i_valid;
    o_ctrl[CTRL_BRANCH_BIT] = (i_opcode == OPC_BRANCH);
    o_ctrl[CTRL_LOAD_BIT]   = (i_opcode == OPC_LOAD);
    o_ctrl[CTRL_STORE_BIT]  = (i_opcode == OPC_STORE);
  end

endmodule

// File: rtl/instruction_fetch_stage.sv
// Single-outstanding instruction fetch: FETCH -> WAIT -> DELIVER, 3 cycles minimum per instruction.
// Holds the delivered instruction until if_ready; a redirect overrides everything and squashes in-flight data.
module instruction_fetch_stage
  import instruction_fetch_stage_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
  parameter int                    CTRL_WIDTH = CTRL_WIDTH_DEFAULT
) (
  input  logic                  clock,
  input  logic                  reset,
  output logic                  imem_req_valid,
  input  logic                  imem_req_ready,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic                  imem_resp_valid,
  input  logic [DATA_WIDTH-1:0] imem_resp_data,
  input  logic                  redirect,
  input  logic [ADDR_WIDTH-1:0] redirect_target,
  output logic                  if_valid,
  input  logic                  if_ready,
  output logic [ADDR_WIDTH-1:0] if_pc,
  output logic [DATA_WIDTH-1:0] if_instruction,
  output logic [CTRL_WIDTH-1:0] if_control_signals
);

  fetch_state_t          r_state;
  fetch_state_t          w_next_state;
  logic [ADDR_WIDTH-1:0] r_pc;
  logic [ADDR_WIDTH-1:0] w_next_pc;
  logic                  r_kill;
  logic                  w_next_kill;
  logic                  w_load;
  logic [ADDR_WIDTH-1:0] r_if_pc;
  logic [DATA_WIDTH-1:0] r_if_instruction;
  logic [ADDR_WIDTH-1:0] w_redirect_pc;

  assign w_redirect_pc = redirect_target & ~ADDR_WIDTH'(3);

  always_comb begin
    w_next_state = r_state;
    w_next_pc    = r_pc;
    w_next_kill  = r_kill;
    w_load       = 1'b0;
    case (r_state)
      ST_FETCH: begin
        if (redirect) begin
          w_next_pc = w_redirect_pc;
          // The old-pc request still goes out if accepted; its data must be dropped.
          if (imem_req_ready) begin
            w_next_state = ST_WAIT;
            w_next_kill  = 1'b1;
          end
        end else if (imem_req_ready) begin
          w_next_state = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (redirect) begin
          w_next_pc = w_redirect_pc;
          if (imem_resp_valid) begin
            w_next_state = ST_FETCH;
            w_next_kill  = 1'b0;
          end else begin
            w_next_kill  = 1'b1;
          end
        end else if (imem_resp_valid) begin
          if (r_kill) begin
            w_next_kill  = 1'b0;
            w_next_state = ST_FETCH;
          end else begin
            w_load       = 1'b1;
            w_next_pc    = r_pc + ADDR_WIDTH'(4);
            w_next_state = ST_DELIVER;
          end
        end
      end
      ST_DELIVER: begin
        if (redirect) begin
          w_next_pc    = w_redirect_pc;
          w_next_state = ST_FETCH;
        end else if (if_ready) begin
          w_next_state = ST_FETCH;
        end
      end
      default: w_next_state = ST_FETCH;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state          <= ST_FETCH;
      r_pc             <= RESET_PC;
      r_kill           <= 1'b0;
      r_if_pc          <= '0;
      r_if_instruction <= '0;
    end else begin
      r_state <= w_next_state;
      r_pc    <= w_next_pc;
      r_kill  <= w_next_kill;
      if (w_load) begin
        r_if_pc          <= r_pc;
        r_if_instruction <= imem_resp_data;
      end
    end
  end

  assign imem_req_valid = (r_state == ST_FETCH) && !reset;
  assign imem_addr      = r_pc;
  assign if_valid       = (r_state == ST_DELIVER);
  assign if_pc          = r_if_pc;
  assign if_instruction = r_if_instruction;

  fetch_predecode #(
    .CTRL_WIDTH (CTRL_WIDTH)
  ) u_predecode (
    .i_valid    (if_valid),
    .i_opcode   (r_if_instruction[DATA_WIDTH-1 -: 6]),
    .o_ctrl     (if_control_signals)
  );

endmodule
